// File: rtl/psg_bus_arb_rr.sv
// Bus arbiter for PSG wave-table channels: fixed-priority or round-robin grant
// with a burst limit, updated only on arbitration events (ce & ack).
module psg_bus_arb_rr #(
    parameter int NCH      = 8,
    parameter int MAXBURST = 4,
    localparam int SELW    = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            ack,
    input  logic            mode,
    input  logic [NCH-1:0]  req,
    output logic [NCH-1:0]  sel,
    output logic [SELW-1:0] seln,
    output logic            gnt_vld,
    output logic            gnt_new
);

    localparam int BMIN = $clog2(MAXBURST + 1);
    localparam int BCW  = (BMIN > SELW) ? BMIN : SELW;
    localparam logic [BCW-1:0] BCAP = BCW'((MAXBURST > 0) ? MAXBURST - 1 : 0);

    logic [BCW-1:0]  burst_cnt;
    logic [SELW-1:0] rr_ptr;
    logic [NCH-1:0]  elig;
    logic [SELW-1:0] win_fix, win_rr, win;
    logic            any;
    logic            same;
    int              idx;

    always_comb begin
        elig    = req;
        win_fix = '0;
        win_rr  = '0;
        idx     = 0;
        // An owner at its burst cap steps aside only if someone else is waiting.
        if (MAXBURST > 0 && gnt_vld && burst_cnt == BCAP && (req & ~sel) != '0)
            elig = req & ~sel;
        any = |elig;
        for (int i = NCH - 1; i >= 0; i--)
            if (elig[i]) win_fix = SELW'(i);
        // Scan downward so the nearest slot after rr_ptr is the last one written.
        for (int k = NCH; k >= 1; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (elig[idx]) win_rr = SELW'(idx);
        end
        win  = mode ? win_rr : win_fix;
        same = gnt_vld && (win == seln);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= '0;
            seln      <= '0;
            gnt_vld   <= 1'b0;
            gnt_new   <= 1'b0;
            burst_cnt <= '0;
            rr_ptr    <= SELW'(NCH - 1);
        end else begin
            gnt_new <= 1'b0;
            if (ce && ack && any) begin
                sel      <= '0;
                sel[win] <= 1'b1;
                seln     <= win;
                gnt_vld  <= 1'b1;
                rr_ptr   <= win;
                gnt_new  <= !same;
                if (!same)
                    burst_cnt <= '0;
                else if (burst_cnt != BCAP)
                    burst_cnt <= burst_cnt + BCW'(1);
            end
        end
    end

endmodule
